// File: rtl/ctrl_pkg.sv
// Shared types and constants for the processor control unit: opcodes, FSM state
// encodings (shown on the board display), ALU select codes and IR field positions.
package ctrl_pkg;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'd0,
    OP_STORE = 4'd1,
    OP_LOAD  = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_HALT  = 4'd5
  } opcode_t;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD_A = 4'd3,
    S_LOAD_B = 4'd4,
    S_STORE  = 4'd5,
    S_ADD    = 4'd6,
    S_SUB    = 4'd7,
    S_HALT   = 4'd8
  } state_t;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  localparam int OP_MSB = 15, OP_LSB = 12;
  localparam int RA_MSB = 11, RA_LSB = 8;
  localparam int RB_MSB = 7,  RB_LSB = 4;
  localparam int RC_MSB = 3,  RC_LSB = 0;
  localparam int LD_ADDR_MSB = 11, LD_ADDR_LSB = 4;
  localparam int LD_REG_MSB  = 3,  LD_REG_LSB  = 0;
  localparam int ST_ADDR_MSB = 7,  ST_ADDR_LSB = 0;

  // Undefined opcodes fall through to FETCH, i.e. behave as NOOP.
  function automatic state_t decode_next(input logic [3:0] op);
    case (op)
      OP_STORE: decode_next = S_STORE;
      OP_LOAD:  decode_next = S_LOAD_A;
      OP_ADD:   decode_next = S_ADD;
      OP_SUB:   decode_next = S_SUB;
      OP_HALT:  decode_next = S_HALT;
      default:  decode_next = S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/instr_reg.sv
// Instruction register: loads on ld_i at the rising clock edge, cleared
// asynchronously by Clr.
module instr_reg #(
  parameter int INSTR_W = 16
) (
  input  logic               Clk,
  input  logic               Clr,
  input  logic               ld_i,
  input  logic [INSTR_W-1:0] d_i,
  output logic [INSTR_W-1:0] q_o
);

  logic [INSTR_W-1:0] ir_q;

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr)       ir_q <= '0;
    else if (ld_i) ir_q <= d_i;
  end

  assign q_o = ir_q;

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle control unit: fetch, decode, 1-2 execute states; Moore outputs
// decoded from state and IR. Optional CTRL_SINGLE_STEP_EN adds a Step input.
module control_fsm
  import ctrl_pkg::*;
#(
  parameter int INSTR_W   = 16,
  parameter int DADDR_W   = 8,
  parameter int RF_ADDR_W = 4
) (
  input  logic                 Clk,
  input  logic                 Clr,
  input  logic [INSTR_W-1:0]   ROM_data,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic                 Step,
`endif
  output logic                 PC_clr,
  output logic                 PC_up,
  output logic [INSTR_W-1:0]   IR_out,
  output logic [DADDR_W-1:0]   D_addr,
  output logic                 D_wr,
  output logic                 RF_s,
  output logic [RF_ADDR_W-1:0] RF_W_addr,
  output logic                 RF_W_en,
  output logic [RF_ADDR_W-1:0] RF_Ra_addr,
  output logic [RF_ADDR_W-1:0] RF_Rb_addr,
  output logic [2:0]           ALU_s0,
  output logic [3:0]           state_out
);

  state_t             state_q;
  logic [INSTR_W-1:0] ir_q;
  logic               go_d;
  logic               ir_ld_d;

`ifdef CTRL_SINGLE_STEP_EN
  assign go_d = Step;
`else
  assign go_d = 1'b1;
`endif

  // FETCH advances (PC increments, IR loads) only on a go cycle.
  assign ir_ld_d = (state_q == S_FETCH) && go_d;

  instr_reg #(.INSTR_W(INSTR_W)) u_ir (
    .Clk  (Clk),
    .Clr  (Clr),
    .ld_i (ir_ld_d),
    .d_i  (ROM_data),
    .q_o  (ir_q)
  );

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q <= S_INIT;
    end else begin
      case (state_q)
        S_INIT:   state_q <= S_FETCH;
        S_FETCH:  if (go_d) state_q <= S_DECODE;
        S_DECODE: state_q <= decode_next(ir_q[OP_MSB:OP_LSB]);
        S_LOAD_A: state_q <= S_LOAD_B;
        S_LOAD_B: state_q <= S_FETCH;
        S_STORE:  state_q <= S_FETCH;
        S_ADD:    state_q <= S_FETCH;
        S_SUB:    state_q <= S_FETCH;
        S_HALT:   state_q <= S_HALT;
        default:  state_q <= S_INIT;
      endcase
    end
  end

  always_comb begin
    PC_clr     = 1'b0;
    PC_up      = 1'b0;
    D_addr     = '0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = '0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    ALU_s0     = ALU_PASS;
    case (state_q)
      S_INIT:  PC_clr = 1'b1;
      S_FETCH: PC_up  = go_d;
      S_LOAD_A, S_LOAD_B: begin
        D_addr    = DADDR_W'(ir_q[LD_ADDR_MSB:LD_ADDR_LSB]);
        RF_s      = 1'b1;
        RF_W_addr = RF_ADDR_W'(ir_q[LD_REG_MSB:LD_REG_LSB]);
        // Write only in the second cycle, once the synchronous RAM data is valid.
        RF_W_en   = (state_q == S_LOAD_B);
      end
      S_STORE: begin
        D_addr     = DADDR_W'(ir_q[ST_ADDR_MSB:ST_ADDR_LSB]);
        RF_Ra_addr = RF_ADDR_W'(ir_q[RA_MSB:RA_LSB]);
        D_wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        RF_Ra_addr = RF_ADDR_W'(ir_q[RA_MSB:RA_LSB]);
        RF_Rb_addr = RF_ADDR_W'(ir_q[RB_MSB:RB_LSB]);
        RF_W_addr  = RF_ADDR_W'(ir_q[RC_MSB:RC_LSB]);
        RF_W_en    = 1'b1;
        ALU_s0     = (state_q == S_ADD) ? ALU_ADD : ALU_SUB;
      end
      default: ;
    endcase
  end

  assign IR_out    = ir_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: per-instruction state/output sequences, Clr abort,
// HALT hold, undefined opcode, and (with CTRL_SINGLE_STEP_EN) single-step gating.
module tb_control_fsm;

  logic        Clk = 1'b0;
  logic        Clr = 1'b1;
  logic [15:0] ROM_data = '0;
  logic        Step = 1'b1;
  logic        PC_clr, PC_up, D_wr, RF_s, RF_W_en;
  logic [15:0] IR_out;
  logic [7:0]  D_addr;
  logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, state_out;
  logic [2:0]  ALU_s0;

  int passed = 0;
  int total  = 0;

  always #5 Clk = ~Clk;

  control_fsm dut (
    .Clk        (Clk),
    .Clr        (Clr),
    .ROM_data   (ROM_data),
`ifdef CTRL_SINGLE_STEP_EN
    .Step       (Step),
`endif
    .PC_clr     (PC_clr),
    .PC_up      (PC_up),
    .IR_out     (IR_out),
    .D_addr     (D_addr),
    .D_wr       (D_wr),
    .RF_s       (RF_s),
    .RF_W_addr  (RF_W_addr),
    .RF_W_en    (RF_W_en),
    .RF_Ra_addr (RF_Ra_addr),
    .RF_Rb_addr (RF_Rb_addr),
    .ALU_s0     (ALU_s0),
    .state_out  (state_out)
  );

  // Reset, then run FETCH of instr; returns at the negedge inside DECODE.
  task automatic start(input logic [15:0] instr);
    @(negedge Clk); Clr = 1'b1;
    @(negedge Clk); Clr = 1'b0; ROM_data = instr;
    @(negedge Clk);
    @(negedge Clk);
  endtask

  task automatic test_reset();
    #2 Clr = 1'b1; #1;
    total++; if (state_out !== 4'd0) $display("FAIL reset_state got %0d want 0", state_out); else passed++;
    total++; if ({PC_clr, PC_up, D_wr, RF_W_en, RF_s} !== 5'b10000)
      $display("FAIL reset_ctrl got %b want 10000", {PC_clr, PC_up, D_wr, RF_W_en, RF_s}); else passed++;
    total++; if (IR_out !== 16'h0) $display("FAIL reset_ir got %h want 0000", IR_out); else passed++;
    @(negedge Clk); Clr = 1'b0; ROM_data = 16'h0000;
    @(negedge Clk);
    total++; if (state_out !== 4'd1 || PC_up !== 1'b1 || PC_clr !== 1'b0)
      $display("FAIL reset_to_fetch got st=%0d up=%b clr=%b want st=1 up=1 clr=0", state_out, PC_up, PC_clr); else passed++;
  endtask

  task automatic test_load();
    start(16'h2A05);
    total++; if (state_out !== 4'd2 || IR_out !== 16'h2A05 || PC_up !== 1'b0)
      $display("FAIL load_decode got st=%0d ir=%h up=%b want st=2 ir=2a05 up=0", state_out, IR_out, PC_up); else passed++;
    @(negedge Clk);
    total++; if (state_out !== 4'd3 || D_addr !== 8'hA0 || RF_W_en !== 1'b0 || RF_s !== 1'b1 || RF_W_addr !== 4'd5)
      $display("FAIL load_a got st=%0d da=%h we=%b s=%b wa=%0d want st=3 da=a0 we=0 s=1 wa=5",
               state_out, D_addr, RF_W_en, RF_s, RF_W_addr); else passed++;
    @(negedge Clk);
    total++; if (state_out !== 4'd4 || D_addr !== 8'hA0 || RF_W_en !== 1'b1 || RF_s !== 1'b1 || RF_W_addr !== 4'd5 || D_wr !== 1'b0)
      $display("FAIL load_b got st=%0d da=%h we=%b s=%b wa=%0d dw=%b want st=4 da=a0 we=1 s=1 wa=5 dw=0",
               state_out, D_addr, RF_W_en, RF_s, RF_W_addr, D_wr); else passed++;
    @(negedge Clk);
    total++; if (state_out !== 4'd1 || RF_W_en !== 1'b0 || PC_up !== 1'b1)
      $display("FAIL load_done got st=%0d we=%b up=%b want st=1 we=0 up=1", state_out, RF_W_en, PC_up); else passed++;
  endtask

  task automatic test_add_sub();
    start(16'h3123);
    @(negedge Clk);
    total++; if (state_out !== 4'd6 || RF_Ra_addr !== 4'd1 || RF_Rb_addr !== 4'd2 || RF_W_addr !== 4'd3 ||
                 ALU_s0 !== 3'b001 || RF_W_en !== 1'b1 || RF_s !== 1'b0 || D_addr !== 8'h00)
      $display("FAIL add got st=%0d ra=%0d rb=%0d wa=%0d alu=%b we=%b s=%b da=%h want 6 1 2 3 001 1 0 00",
               state_out, RF_Ra_addr, RF_Rb_addr, RF_W_addr, ALU_s0, RF_W_en, RF_s, D_addr); else passed++;
    @(negedge Clk);
    total++; if (state_out !== 4'd1 || RF_W_en !== 1'b0)
      $display("FAIL add_done got st=%0d we=%b want st=1 we=0", state_out, RF_W_en); else passed++;
    start(16'h4ABC);
    @(negedge Clk);
    total++; if (state_out !== 4'd7 || RF_Ra_addr !== 4'hA || RF_Rb_addr !== 4'hB || RF_W_addr !== 4'hC ||
                 ALU_s0 !== 3'b010 || RF_W_en !== 1'b1)
      $display("FAIL sub got st=%0d ra=%h rb=%h wa=%h alu=%b we=%b want 7 a b c 010 1",
               state_out, RF_Ra_addr, RF_Rb_addr, RF_W_addr, ALU_s0, RF_W_en); else passed++;
  endtask

  task automatic test_store();
    start(16'h1367);
    @(negedge Clk);
    total++; if (state_out !== 4'd5 || RF_Ra_addr !== 4'd3 || D_addr !== 8'h67 || D_wr !== 1'b1 ||
                 RF_W_en !== 1'b0 || ALU_s0 !== 3'b000 || RF_W_addr !== 4'd0)
      $display("FAIL store got st=%0d ra=%0d da=%h dw=%b we=%b alu=%b wa=%0d want 5 3 67 1 0 000 0",
               state_out, RF_Ra_addr, D_addr, D_wr, RF_W_en, ALU_s0, RF_W_addr); else passed++;
    @(negedge Clk);
    total++; if (state_out !== 4'd1 || D_wr !== 1'b0)
      $display("FAIL store_done got st=%0d dw=%b want st=1 dw=0", state_out, D_wr); else passed++;
  endtask

  task automatic test_halt();
    int bad = 0;
    start(16'h5000);
    ROM_data = 16'h3123;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (state_out !== 4'd8 || PC_up !== 1'b0 || RF_W_en !== 1'b0 || D_wr !== 1'b0) bad++;
    end
    total++; if (bad != 0) $display("FAIL halt_hold got %0d bad cycles want 0 (st=%0d)", bad, state_out); else passed++;
  endtask

  task automatic test_undefined();
    start(16'hF000);
    total++; if (state_out !== 4'd2) $display("FAIL undef_decode got st=%0d want 2", state_out); else passed++;
    @(negedge Clk);
    total++; if (state_out !== 4'd1 || RF_W_en !== 1'b0 || D_wr !== 1'b0)
      $display("FAIL undef_noop got st=%0d we=%b dw=%b want 1 0 0", state_out, RF_W_en, D_wr); else passed++;
  endtask

  task automatic test_back_to_back();
    int ups = 0;
    start(16'h0000);
    ROM_data = 16'h3456;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      if (PC_up === 1'b1) ups++;
    end
    // NOOP decode -> FETCH(3456) -> DECODE -> ADD
    total++; if (state_out !== 4'd6 || IR_out !== 16'h3456 || RF_W_addr !== 4'd6 || ups != 1)
      $display("FAIL b2b got st=%0d ir=%h wa=%0d ups=%0d want 6 3456 6 1", state_out, IR_out, RF_W_addr, ups); else passed++;
  endtask

  task automatic test_clr_mid();
    start(16'h3123);
    @(negedge Clk);
    #2 Clr = 1'b1; #1;
    total++; if (state_out !== 4'd0 || PC_clr !== 1'b1 || RF_W_en !== 1'b0 || IR_out !== 16'h0)
      $display("FAIL clr_mid got st=%0d clr=%b we=%b ir=%h want 0 1 0 0000", state_out, PC_clr, RF_W_en, IR_out); else passed++;
    @(negedge Clk); Clr = 1'b0;
    @(negedge Clk);
    total++; if (state_out !== 4'd1) $display("FAIL clr_release got st=%0d want 1", state_out); else passed++;
  endtask

`ifdef CTRL_SINGLE_STEP_EN
  task automatic test_single_step();
    int bad = 0;
    int ups = 0;
    Step = 1'b0;
    @(negedge Clk); Clr = 1'b1;
    @(negedge Clk); Clr = 1'b0; ROM_data = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      if (state_out !== 4'd1 || PC_up !== 1'b0) bad++;
    end
    total++; if (bad != 0) $display("FAIL step_hold got %0d bad cycles want 0", bad); else passed++;
    Step = 1'b1; #1;
    if (PC_up === 1'b1) ups++;
    @(negedge Clk); Step = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (PC_up === 1'b1) ups++;
      @(negedge Clk);
    end
    total++; if (ups != 1 || state_out !== 4'd1) $display("FAIL step_pulse got ups=%0d st=%0d want 1 1", ups, state_out); else passed++;
    Step = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_add_sub();
    test_store();
    test_halt();
    test_undefined();
    test_back_to_back();
    test_clr_mid();
`ifdef CTRL_SINGLE_STEP_EN
    test_single_step();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
